// File: rtl/vertex_unpack_pkg.sv
// Shared types, constants and the component extension helper for the vertex unpacker.
// VERTEX_UNPACK_SIGNED_EN selects sign extension of components (default: zero extension).
package vertex_pkg;

  localparam int unsigned COMP_WIDTH = 9;
  localparam int unsigned FRAC_BITS  = 16;
  localparam int unsigned OUT_WIDTH  = 32;
  localparam int unsigned CNT_WIDTH  = 16;
  localparam int unsigned INT_WIDTH  = OUT_WIDTH - FRAC_BITS;

  localparam logic [OUT_WIDTH-1:0] FIXED_ONE = OUT_WIDTH'(1) << FRAC_BITS;

  typedef enum logic {
    COLLECT,
    PRESENT
  } state_e;

  typedef enum logic [1:0] {
    BEAT_X,
    BEAT_Y,
    BEAT_Z
  } beat_e;

  // Index 0 = x, index 3 = w
  typedef logic [3:0][OUT_WIDTH-1:0] vec_t;

  localparam vec_t VEC_RESET = {FIXED_ONE, {(3 * OUT_WIDTH){1'b0}}};

  // Widen a raw component to the integer part, then place it above the fraction.
  function automatic logic [OUT_WIDTH-1:0] fixed_extend(input logic [COMP_WIDTH-1:0] comp);
    logic [INT_WIDTH-1:0] ext;
`ifdef VERTEX_UNPACK_SIGNED_EN
    ext = {{(INT_WIDTH - COMP_WIDTH){comp[COMP_WIDTH-1]}}, comp};
`else
    ext = {{(INT_WIDTH - COMP_WIDTH){1'b0}}, comp};
`endif
    return {ext, {FRAC_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/vertex_unpack_if.sv
// Component stream in and assembled-vertex handshake out of the vertex unpacker.
interface vertex_unpack_if;
  import vertex_pkg::*;

  logic                  s_axis_tvalid;
  logic [COMP_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tready;
  logic                  valid_out;
  logic                  ready_in;
  vec_t                  vec_out;

  modport slave (
    input  s_axis_tvalid,
    input  s_axis_tdata,
    input  ready_in,
    output s_axis_tready,
    output valid_out,
    output vec_out
  );

  modport master (
    output s_axis_tvalid,
    output s_axis_tdata,
    output ready_in,
    input  s_axis_tready,
    input  valid_out,
    input  vec_out
  );

endinterface

// File: rtl/vertex_unpack.sv
// Drains x, y, z components from the vertex FIFO and presents {x, y, z, 1.0} in Q16.16.
// VERTEX_UNPACK_SIGNED_EN (in vertex_pkg) selects signed components.
module vertex_unpack
  import vertex_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  vertex_unpack_if.slave       vif,
  input  logic                 sync_in,
  output logic [CNT_WIDTH-1:0] vertex_count
);

  state_e                 state_q, state_d;
  beat_e                  beat_q, beat_d;
  vec_t                   vec_q, vec_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic                   tready_q, tready_d;
  logic                   valid_q, valid_d;
  logic                   beat_acc;
  logic [OUT_WIDTH-1:0]   comp_ext;

  assign beat_acc = vif.s_axis_tvalid && tready_q;
  assign comp_ext = fixed_extend(vif.s_axis_tdata);

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: Z beat completes a vertex, downstream handshake releases it
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (!sync_in && beat_acc && (beat_q == BEAT_Z)) state_d = PRESENT;
      PRESENT: if (vif.ready_in) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // Registered handshake decode, looking one state ahead
  always_comb begin
    tready_d = (state_d == COLLECT);
    valid_d  = (state_d == PRESENT);
  end

  // Beat counter, vector assembly and accepted-vertex counter
  always_comb begin
    beat_d  = beat_q;
    vec_d   = vec_q;
    count_d = count_q;
    case (state_q)
      COLLECT: begin
        if (sync_in) begin
          beat_d = BEAT_X;
        end else if (beat_acc) begin
          case (beat_q)
            BEAT_X: begin
              vec_d[0] = comp_ext;
              beat_d   = BEAT_Y;
            end
            BEAT_Y: begin
              vec_d[1] = comp_ext;
              beat_d   = BEAT_Z;
            end
            BEAT_Z: begin
              vec_d[2] = comp_ext;
              beat_d   = BEAT_X;
            end
            default: beat_d = BEAT_X;
          endcase
        end
      end
      PRESENT: if (vif.ready_in) count_d = count_q + CNT_WIDTH'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      beat_q   <= BEAT_X;
      vec_q    <= VEC_RESET;
      count_q  <= '0;
      tready_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      beat_q   <= beat_d;
      vec_q    <= vec_d;
      count_q  <= count_d;
      tready_q <= tready_d;
      valid_q  <= valid_d;
    end
  end

  assign vif.s_axis_tready = tready_q;
  assign vif.valid_out     = valid_q;
  assign vif.vec_out       = vec_q;
  assign vertex_count      = count_q;

endmodule

// File: tb/tb_vertex_unpack.sv
// Bench for vertex_unpack: queue-based reference model checked every cycle plus directed literals.
module tb_vertex_unpack;
  import vertex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sync;
  logic [15:0] vcount;

  vertex_unpack_if vif();

  vertex_unpack dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .vif          (vif),
    .sync_in      (sync),
    .vertex_count (vcount)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Inputs as seen by the active edge
  logic       have = 1'b0;
  logic       c_rst, c_tv, c_rdy, c_sync;
  logic [8:0] c_td;

  // Reference model state
  int          pend[$];
  logic [31:0] m_vec[4];
  logic        m_rdy, m_valid, m_acc;
  logic [15:0] m_count;

`ifdef VERTEX_UNPACK_SIGNED_EN
  localparam logic [31:0] EXP_1FD = 32'hFFFD0000;
`else
  localparam logic [31:0] EXP_1FD = 32'h01FD0000;
`endif

  function automatic logic [31:0] m_ext(input int c);
    int v;
    v = c;
`ifdef VERTEX_UNPACK_SIGNED_EN
    if (c > 255) v = c - 512;
`endif
    return 32'(v * 65536);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    have   <= 1'b1;
    c_rst  <= rst;
    c_tv   <= vif.s_axis_tvalid;
    c_td   <= vif.s_axis_tdata;
    c_rdy  <= vif.ready_in;
    c_sync <= sync;
    cyc    <= cyc + 1;
  end

  // Model step for the edge just taken, then compare every output
  always @(negedge clk) begin
    if (have) begin
      if (c_rst) begin
        pend.delete();
        m_valid = 1'b0;
        m_rdy   = 1'b0;
        m_count = 16'd0;
        m_vec   = '{32'd0, 32'd0, 32'd0, 32'h00010000};
      end else if (m_valid) begin
        if (c_rdy) begin
          m_valid = 1'b0;
          m_rdy   = 1'b1;
          m_count = 16'(m_count + 16'd1);
        end
      end else begin
        m_acc = c_tv && m_rdy;
        m_rdy = 1'b1;
        if (c_sync) begin
          pend.delete();
        end else if (m_acc) begin
          pend.push_back(int'(c_td));
          m_vec[pend.size() - 1] = m_ext(int'(c_td));
          if (pend.size() == 3) begin
            pend.delete();
            m_valid = 1'b1;
            m_rdy   = 1'b0;
          end
        end
      end
      check("model_tready", 32'(vif.s_axis_tready), 32'(m_rdy));
      check("model_valid", 32'(vif.valid_out), 32'(m_valid));
      check("model_count", 32'(vcount), 32'(m_count));
      for (int i = 0; i < 4; i++) check($sformatf("model_vec%0d", i), vif.vec_out[i], m_vec[i]);
    end
  end

  task automatic send_beat(input int v);
    int n;
    n = 0;
    vif.s_axis_tdata  = 9'(v);
    vif.s_axis_tvalid = 1'b1;
    while (vif.s_axis_tready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_err++;
      $display("FAIL beat_timeout: tready=%b after %0d cycles, required 1", vif.s_axis_tready, n);
    end
    @(negedge clk);
  endtask

  task automatic send_vertex(input int x, input int y, input int z);
    send_beat(x);
    send_beat(y);
    send_beat(z);
    vif.s_axis_tvalid = 1'b0;
  endtask

  int c0;

  initial begin
    rst = 1'b1;
    sync = 1'b0;
    vif.s_axis_tvalid = 1'b0;
    vif.s_axis_tdata  = '0;
    vif.ready_in      = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_tready", 32'(vif.s_axis_tready), 32'd0);
    check("rst_valid", 32'(vif.valid_out), 32'd0);
    check("rst_vec3", vif.vec_out[3], 32'h00010000);
    check("rst_count", 32'(vcount), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tready", 32'(vif.s_axis_tready), 32'd1);

    // Basic vertex
    send_vertex(5, 'h1FD, 'hFF);
    check("basic_valid", 32'(vif.valid_out), 32'd1);
    check("basic_x", vif.vec_out[0], 32'h00050000);
    check("basic_y", vif.vec_out[1], EXP_1FD);
    check("basic_z", vif.vec_out[2], 32'h00FF0000);
    check("basic_w", vif.vec_out[3], 32'h00010000);
    @(negedge clk);
    check("basic_count", 32'(vcount), 32'd1);

    // Downstream backpressure with a pending beat offered
    vif.ready_in = 1'b0;
    send_vertex(1, 2, 3);
    vif.s_axis_tvalid = 1'b1;
    vif.s_axis_tdata  = 9'd9;
    repeat (10) @(negedge clk);
    check("bp_valid", 32'(vif.valid_out), 32'd1);
    check("bp_tready", 32'(vif.s_axis_tready), 32'd0);
    check("bp_vec2", vif.vec_out[2], 32'h00030000);
    vif.ready_in = 1'b1;
    @(negedge clk);
    vif.s_axis_tvalid = 1'b0;
    check("bp_count", 32'(vcount), 32'd2);
    check("bp_tready_back", 32'(vif.s_axis_tready), 32'd1);

    // Back-to-back
    c0 = cyc;
    for (int i = 0; i < 6; i++) send_beat(11 + i);
    vif.s_axis_tvalid = 1'b0;
    @(negedge clk);
    check("b2b_count", 32'(vcount), 32'd4);
    check("b2b_cycles", 32'(cyc - c0), 32'd8);

    // Sync drops the partial vertex and the coincident beat
    send_beat(10);
    send_beat(20);
    sync = 1'b1;
    send_beat(7);
    sync = 1'b0;
    send_vertex(1, 2, 3);
    check("sync_valid", 32'(vif.valid_out), 32'd1);
    check("sync_x", vif.vec_out[0], 32'h00010000);
    check("sync_y", vif.vec_out[1], 32'h00020000);
    check("sync_z", vif.vec_out[2], 32'h00030000);
    @(negedge clk);
    check("sync_count", 32'(vcount), 32'd5);

    // Reset mid-vertex
    send_beat(30);
    send_beat(40);
    vif.s_axis_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tready", 32'(vif.s_axis_tready), 32'd0);
    check("midrst_x", vif.vec_out[0], 32'd0);
    check("midrst_y", vif.vec_out[1], 32'd0);
    check("midrst_count", 32'(vcount), 32'd0);
    @(negedge clk);

    // Counter wrap: preload near all-ones
    @(posedge clk);
    #2;
    force dut.count_q = 16'hFFFE;
    m_count = 16'hFFFE;
    @(posedge clk);
    #2;
    release dut.count_q;
    @(negedge clk);
    send_vertex(4, 5, 6);
    @(negedge clk);
    check("wrap_ffff", 32'(vcount), 32'h0000FFFF);
    send_vertex(7, 8, 9);
    @(negedge clk);
    check("wrap_zero", 32'(vcount), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 199) == 0);
      sync = ($urandom_range(0, 29) == 0);
      vif.s_axis_tvalid = ($urandom_range(0, 9) < 7);
      vif.s_axis_tdata  = 9'($urandom_range(0, 511));
      vif.ready_in      = ($urandom_range(0, 9) < 6);
      @(negedge clk);
    end
    rst = 1'b0;
    sync = 1'b0;
    vif.s_axis_tvalid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
